// File: rtl/switch_mcu_alu_exec.sv
// Multi-cycle integer execution unit for RV32I/RV64I OP and OP-IMM with its own regfile ports.
// Define SWITCH_MCU_ALU_EXEC_FASTSHIFT_EN to replace the iterative shifter with a barrel shifter.
module switch_mcu_alu_exec #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  input  logic [3:0]      in_op,
  input  logic            in_use_imm,
  input  logic [11:0]     in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rdata_1,
  input  logic [XLEN-1:0] in_rdata_2,
  output logic [4:0]      out_raddr_1,
  output logic            out_ren_1,
  output logic [4:0]      out_raddr_2,
  output logic            out_ren_2,
  output logic [4:0]      out_waddr,
  output logic            out_wen,
  output logic [XLEN-1:0] out_wdata,
  output logic            out_busy,
  output logic            out_done,
  output logic            out_err
);

  localparam int unsigned ShW = $clog2(XLEN);
  // Upper immediate pattern that marks SRAI (imm[10] set, shamt below)
  localparam logic [11:0] SraImm = 12'h400;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSll  = 4'd2;
  localparam logic [3:0] OpSlt  = 4'd3;
  localparam logic [3:0] OpSltu = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpAnd  = 4'd9;

  typedef enum logic [2:0] {StIdle, StRd, StCap, StExec, StWb, StErr} state_e;

  state_e          state_q;
  logic [3:0]      op_q;
  logic            use_imm_q;
  logic [11:0]     imm_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] b_q;
  logic [ShW-1:0]  rem_q;

  logic            start_illegal;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] b_sel;
  logic            is_shift;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] exec_res;
  logic [ShW-1:0]  step;
  logic            shift_last;
  logic            exec_last;

  always_comb begin
    start_illegal = 1'b0;
    if (in_op > OpAnd) begin
      start_illegal = 1'b1;
    end else if (in_use_imm) begin
      case (in_op)
        OpSub:        start_illegal = 1'b1;
        OpSll, OpSrl: start_illegal = (in_imm[11:ShW] != '0);
        OpSra:        start_illegal = (in_imm[11:ShW] != '0) &&
                                      (in_imm[11:ShW] != SraImm[11:ShW]);
        default:      start_illegal = 1'b0;
      endcase
    end
  end

  assign imm_ext  = {{(XLEN-12){imm_q[11]}}, imm_q};
  assign b_sel    = use_imm_q ? imm_ext : in_rdata_2;
  assign is_shift = op_q inside {OpSll, OpSrl, OpSra};

  always_comb begin
    alu_res = '0;
    case (op_q)
      OpAdd:   alu_res = acc_q + b_q;
      OpSub:   alu_res = acc_q - b_q;
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(acc_q) < $signed(b_q)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, acc_q < b_q};
      OpXor:   alu_res = acc_q ^ b_q;
      OpOr:    alu_res = acc_q | b_q;
      OpAnd:   alu_res = acc_q & b_q;
      default: alu_res = '0;
    endcase
  end

`ifdef SWITCH_MCU_ALU_EXEC_FASTSHIFT_EN
  assign step       = rem_q;
  assign shift_last = 1'b1;

  always_comb begin
    case (op_q)
      OpSll:   shifted = acc_q << rem_q;
      OpSra:   shifted = $signed(acc_q) >>> rem_q;
      default: shifted = acc_q >> rem_q;
    endcase
  end
`else
  localparam int unsigned   StW     = $clog2(SHIFT_STEP + 1);
  localparam logic [ShW-1:0] StepMax = ShW'(SHIFT_STEP);

  logic [StW-1:0] step_n;

  // Only the narrow step amount reaches the shifter, keeping it a small mux per bit.
  assign step       = (rem_q > StepMax) ? StepMax : rem_q;
  assign step_n     = step[StW-1:0];
  assign shift_last = (rem_q <= StepMax);

  always_comb begin
    case (op_q)
      OpSll:   shifted = acc_q << step_n;
      OpSra:   shifted = $signed(acc_q) >>> step_n;
      default: shifted = acc_q >> step_n;
    endcase
  end
`endif

  assign exec_res  = is_shift ? shifted : alu_res;
  assign exec_last = !is_shift || shift_last;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      rd_q        <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      out_raddr_1 <= '0;
      out_ren_1   <= 1'b0;
      out_raddr_2 <= '0;
      out_ren_2   <= 1'b0;
      out_waddr   <= '0;
      out_wen     <= 1'b0;
      out_wdata   <= '0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      out_ren_1 <= 1'b0;
      out_ren_2 <= 1'b0;
      out_wen   <= 1'b0;
      out_done  <= 1'b0;
      out_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_start) begin
            op_q      <= in_op;
            use_imm_q <= in_use_imm;
            imm_q     <= in_imm;
            rd_q      <= in_rd;
            out_busy  <= 1'b1;
            if (start_illegal) begin
              state_q  <= StErr;
              out_done <= 1'b1;
              out_err  <= 1'b1;
            end else begin
              state_q     <= StRd;
              out_ren_1   <= 1'b1;
              out_raddr_1 <= in_rs1;
              out_ren_2   <= !in_use_imm;
              out_raddr_2 <= in_use_imm ? 5'd0 : in_rs2;
            end
          end
        end
        StRd: begin
          state_q     <= StCap;
          out_raddr_1 <= '0;
          out_raddr_2 <= '0;
        end
        StCap: begin
          state_q <= StExec;
          acc_q   <= in_rdata_1;
          b_q     <= b_sel;
          rem_q   <= b_sel[ShW-1:0];
        end
        StExec: begin
          acc_q <= shifted;
          rem_q <= rem_q - step;
          if (exec_last) begin
            state_q   <= StWb;
            out_wdata <= exec_res;
            out_waddr <= rd_q;
            out_wen   <= (rd_q != 5'd0);
            out_done  <= 1'b1;
          end
        end
        StWb: begin
          state_q   <= StIdle;
          out_busy  <= 1'b0;
          out_waddr <= '0;
          out_wdata <= '0;
        end
        StErr: begin
          state_q  <= StIdle;
          out_busy <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
